storage_banked: RTL
===================

// Module: storage_banked
// PURPOSE
//  Parametrised management-area storage: BANKS independent single-cycle SRAM banks behind one
//  read/write port and one read-only port, each with a valid/ready request handshake and a
//  registered read-return strobe. Adds post-reset zero-fill sequencing and same-cycle
//  write/read forwarding. Sits between the management core bus adapter and on-chip storage.
// PARAMETERS
//  BANKS           2   number of banks; power of two, >= 2
//  ADDR_W          8   word-address width per bank (depth = 2**ADDR_W)
//  DATA_W          32  word width; multiple of 8
//  CLEAR_ON_RESET  1   1: zero-fill all banks after reset; 0: no fill
//  (local) BSEL_W = $clog2(BANKS); FULL_A = BSEL_W+ADDR_W
// PORTS
//  mgmt_clk     in   1         sole clock; all logic on rising edge
//  mgmt_rst     in   1         synchronous, active-high reset
//  rw_valid     in   1         RW request present
//  rw_ready     out  1         RW request accepted when rw_valid&&rw_ready
//  rw_we        in   1         1 = write, 0 = read
//  rw_mask      in   DATA_W/8  byte write enables (bit i -> byte i)
//  rw_addr      in   FULL_A    [FULL_A-1:ADDR_W] bank select, [ADDR_W-1:0] word
//  rw_wdata     in   DATA_W    write data
//  rw_rdata     out  DATA_W    read return data
//  rw_rvalid    out  1         1-cycle strobe: rw_rdata valid
//  ro_valid     in   1         RO read request present
//  ro_ready     out  1         RO request accepted when ro_valid&&ro_ready
//  ro_addr      in   FULL_A    RO address, same split as rw_addr
//  ro_rdata     out  DATA_W    RO read return data
//  ro_rvalid    out  1         1-cycle strobe: ro_rdata valid
//  init_done    out  1         high once banks are usable; stays high until next reset
// BEHAVIOUR
//  - Reset (cycle mgmt_rst=1): rw_ready=ro_ready=0, rw_rvalid=ro_rvalid=0, rw_rdata=ro_rdata=0,
//    init_done=0, clear counter=0. Memory contents not reset.
//  - FSM: CLEAR -> READY. Exit reset into CLEAR if CLEAR_ON_RESET=1, else directly to READY.
//  - CLEAR: counter walks 0..2**ADDR_W-1, writing all-zero to that word of every bank each cycle;
//    exactly 2**ADDR_W cycles; on last word -> READY. Requests ignored (ready=0) in CLEAR.
//  - Reset asserted mid-CLEAR: counter restarts at 0, full sweep repeats.
//  - READY: rw_ready=ro_ready=init_done=1 (registered state, combinational ready). No other
//    backpressure; one request per port per cycle.
//  - Read latency: accepted read in cycle N -> rdata valid, rvalid=1 in cycle N+1 only.
//    rdata holds last returned value while rvalid=0. Writes produce no rvalid.
//  - Writes: bytes with rw_mask[i]=1 updated at end of accept cycle; rw_mask=0 is a no-op.
//  - Bank select decoded from top BSEL_W bits; every address maps to a real word.
//  - Collision, same cycle, RW write + RO read to same bank/word: RO returns the post-write word
//    (masked bytes new, unmasked bytes old) -- write-first forwarding.
//  - Different bank or word: ports fully independent, both complete in one cycle.
//  - Read in cycle N+1 of a word written in cycle N returns new data.
//  - Read-return pipeline register (bank index + forward flag) holds 1 cycle; no outstanding
//    state beyond it. Reset while a read is in flight: rvalid is 0 in the following cycle.
// TESTING
//  1. Reset 1 cycle, CLEAR_ON_RESET=1, ADDR_W=8: init_done rises exactly 256 cycles after reset
//     release; ready=0 throughout; any read afterwards returns 0x00000000.
//  2. RW write bank1/word 0x10 = 0xDEADBEEF mask 4'hF, next cycle RW read -> rw_rvalid one cycle
//     later, rw_rdata=0xDEADBEEF; RO read bank0/word 0x10 -> 0x00000000.
//  3. Partial write mask 4'b0101 data 0x11223344 over 0xAABBCCDD -> read returns 0xAA22CC44.
//  4. Same cycle: RW write bank0/0x05 = 0xCAFEF00D mask 4'hF and RO read bank0/0x05
//     -> ro_rdata=0xCAFEF00D, ro_rvalid=1 next cycle.
//  5. Assert mgmt_rst at clear counter=100 -> init_done stays 0, rises 256 cycles after release.
//  6. Back-to-back reads both ports every cycle to BANKS=4 distinct banks -> rvalid continuous,
//     data in request order, no dropped or duplicated returns.

Source files
------------

// File: rtl/storage_banked.sv
// ---------------------------------------------------------------------------
// storage_banked
//   Management-area storage built from BANKS single-cycle SRAM banks behind a
//   read/write port and a read-only port. After reset the banks are optionally
//   zero-filled one word index per cycle (all banks in parallel) before any
//   request is accepted. A write on the RW port and a read on the RO port to
//   the same word in the same cycle return the post-write word on the RO port.
//
// Ports
//   mgmt_clk, mgmt_rst        clock, synchronous active-high reset
//   rw_valid / rw_ready       RW request handshake
//   rw_we, rw_mask            1 = write; byte enables for writes
//   rw_addr, rw_wdata         {bank, word} address; write data
//   rw_rdata, rw_rvalid       read return data, one-cycle return strobe
//   ro_valid / ro_ready       RO request handshake
//   ro_addr                   {bank, word} address
//   ro_rdata, ro_rvalid       read return data, one-cycle return strobe
//   init_done                 banks usable (zero-fill finished)
// ---------------------------------------------------------------------------
module storage_banked #(
    parameter int BANKS          = 2,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                  mgmt_clk,
    input  logic                                  mgmt_rst,
    input  logic                                  rw_valid,
    output logic                                  rw_ready,
    input  logic                                  rw_we,
    input  logic [DATA_W/8-1:0]                   rw_mask,
    input  logic [$clog2(BANKS)+ADDR_W-1:0]       rw_addr,
    input  logic [DATA_W-1:0]                     rw_wdata,
    output logic [DATA_W-1:0]                     rw_rdata,
    output logic                                  rw_rvalid,
    input  logic                                  ro_valid,
    output logic                                  ro_ready,
    input  logic [$clog2(BANKS)+ADDR_W-1:0]       ro_addr,
    output logic [DATA_W-1:0]                     ro_rdata,
    output logic                                  ro_rvalid,
    output logic                                  init_done
);

    localparam int BSEL_W = $clog2(BANKS);
    localparam int FULL_A = BSEL_W + ADDR_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

    logic [DATA_W-1:0]   mem [BANKS][DEPTH];

    logic [BSEL_W-1:0]   rw_bank, ro_bank;
    logic [ADDR_W-1:0]   rw_word, ro_word;
    logic                ready_w;
    logic                clearing;
    logic                rw_wr, rw_rd, ro_rd;
    logic                ro_fwd;
    logic [DATA_W-1:0]   ro_word_data;

    logic [DATA_W-1:0]   rw_rdata_q, ro_rdata_q;
    logic                rw_rvalid_q, ro_rvalid_q;

    assign rw_bank = rw_addr[FULL_A-1:ADDR_W];
    assign rw_word = rw_addr[ADDR_W-1:0];
    assign ro_bank = ro_addr[FULL_A-1:ADDR_W];
    assign ro_word = ro_addr[ADDR_W-1:0];

    // Ready is gated by the reset input so nothing is accepted in a reset cycle
    // even when the state register still holds READY from before the reset.
    assign ready_w  = (state_q == ST_READY) && !mgmt_rst;
    assign clearing = (state_q == ST_CLEAR) && !mgmt_rst;

    assign rw_ready  = ready_w;
    assign ro_ready  = ready_w;
    assign init_done = ready_w;

    assign rw_wr = rw_valid && ready_w && rw_we;
    assign rw_rd = rw_valid && ready_w && !rw_we;
    assign ro_rd = ro_valid && ready_w;
    assign ro_fwd = rw_wr && (rw_addr == ro_addr);

    // ---------------------------------------------------------------- FSM
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                state_d   = ST_READY;
                clr_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge mgmt_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (mgmt_rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ------------------------------------------------------------- storage
    // NOTE: the memory array has no reset term; contents are only defined by the zero-fill sweep or by writes.
    always_ff @(posedge mgmt_clk) begin
        if (clearing) begin
            for (int b = 0; b < BANKS; b++) begin
                mem[b][clr_cnt_q] <= '0;
            end
        end else if (rw_wr) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (rw_mask[i]) begin
                    mem[rw_bank][rw_word][8*i +: 8] <= rw_wdata[8*i +: 8];
                end
            end
        end
    end

    // Write-first view of the RO word: bytes being written this cycle come
    // from the write data, the rest from the array.
    always_comb begin
        ro_word_data = mem[ro_bank][ro_word];
        if (ro_fwd) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (rw_mask[i]) begin
                    ro_word_data[8*i +: 8] = rw_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------ read returns
    // Data registers only load on an accepted read, so they hold the last
    // returned value while the strobe is low.
    always_ff @(posedge mgmt_clk) begin
        if (mgmt_rst) begin
            rw_rvalid_q <= 1'b0;
            ro_rvalid_q <= 1'b0;
            rw_rdata_q  <= '0;
            ro_rdata_q  <= '0;
        end else begin
            rw_rvalid_q <= rw_rd;
            ro_rvalid_q <= ro_rd;
            if (rw_rd) begin
                rw_rdata_q <= mem[rw_bank][rw_word];
            end
            if (ro_rd) begin
                ro_rdata_q <= ro_word_data;
            end
        end
    end

    assign rw_rdata  = rw_rdata_q;
    assign rw_rvalid = rw_rvalid_q;
    assign ro_rdata  = ro_rdata_q;
    assign ro_rvalid = ro_rvalid_q;

endmodule
